// File: rtl/regrw_pkg.sv
// Shared definitions for the one-hot serial register writer and its read-side
// scanner.
//   state_e        : read FSM states (IDLE, SHIFT)
//   DEFAULT_WIDTH  : register width shared by writer and reader
//   onehot_idx()   : decodes a select word into {is_onehot, idx}
package regrw_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // onehot_idx() works on a 32-bit container, so WIDTH must not exceed 32.
  localparam int MAX_WIDTH = 32;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  typedef struct packed {
    logic        is_onehot;
    logic [31:0] idx;
  } onehot_t;

  // Reports whether exactly one bit is set and, if so, which one.
  // idx is only meaningful when is_onehot is set.
  function automatic onehot_t onehot_idx(input logic [MAX_WIDTH-1:0] vec);
    onehot_t res;
    int      ones;
    res  = '0;
    ones = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (vec[i]) begin
        ones    = ones + 1;
        res.idx = 32'(i);
      end
    end
    res.is_onehot = (ones == 1);
    return res;
  endfunction

endpackage

// File: rtl/regread_onehot_chk.sv
// Purely combinational classifier for a one-hot select word.
// Ports:
//   ctrl_i   : select word (WIDTH bits)
//   zero_o   : no bit set
//   onehot_o : exactly one bit set
//   multi_o  : two or more bits set
//   idx_o    : index of the set bit (valid only with onehot_o)
module regread_onehot_chk
  import regrw_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] ctrl_i,
  output logic             zero_o,
  output logic             onehot_o,
  output logic             multi_o,
  output logic [CNT_W-1:0] idx_o
);

  onehot_t dec;

  always_comb begin
    dec      = onehot_idx(MAX_WIDTH'(ctrl_i));
    zero_o   = ~|ctrl_i;
    onehot_o = dec.is_onehot;
    multi_o  = ~zero_o & ~dec.is_onehot;
    idx_o    = CNT_W'(dec.idx);
  end

endmodule

// File: rtl/regread_scan.sv
// Read side of the one-hot serial register writer. Returns either a single
// selected bit of rin (one-hot ctrl) or a full LSB-first scan of rin (start).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ctrl       : one-hot bit select for single reads, zero = no request
//   start      : scan request, honoured only when idle and not busy
//   rin        : parallel register contents from the writer
//   out        : serial read data (registered)
//   out_valid  : out carries a valid bit
//   out_last   : final bit of a scan
//   busy       : scan in progress
//   err        : one-cycle pulse when ctrl had several bits set
module regread_scan
  import regrw_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ctrl,
  input  logic             start,
  input  logic [WIDTH-1:0] rin,
  output logic             out,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             err
);

  // The counter holds the index of the bit currently on out, so the edge
  // that moves it to WIDTH-1 is the one that emits the final bit.
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_q;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
  logic             err_q;

  logic             ctrl_zero;
  logic             ctrl_onehot;
  logic             ctrl_multi;
  logic [CNT_W-1:0] ctrl_idx;

  regread_onehot_chk #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .ctrl_i   (ctrl),
    .zero_o   (ctrl_zero),
    .onehot_o (ctrl_onehot),
    .multi_o  (ctrl_multi),
    .idx_o    (ctrl_idx)
  );

  // Bit 0 of the snapshot is emitted on the start edge itself so the first
  // scan bit appears the cycle after start; the shift register keeps the
  // remaining WIDTH-1 bits. Busy stays high through the out_last cycle, and
  // that cycle already sits in IDLE, so start is additionally gated by busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !busy_q) begin
            shift_q <= rin >> 1;
            cnt_q   <= '0;
            out_q   <= rin[0];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            unique case (1'b1)
              ctrl_onehot: begin
                out_q   <= rin[ctrl_idx];
                valid_q <= 1'b1;
              end
              ctrl_multi: err_q <= 1'b1;
              ctrl_zero:  ;
            endcase
          end
        end
        SHIFT: begin
          out_q   <= shift_q[0];
          shift_q <= shift_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
          if (cnt_q == PRE_LAST) begin
            last_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_regread_scan.sv
// Bench for regread_scan: directed vectors with literal expectations plus a
// queue-based reference model compared against the DUT on every cycle.
module tb_regread_scan;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] ctrlIn = '0;
  logic             startIn = 1'b0;
  logic [WIDTH-1:0] rinIn = '0;
  logic             out;
  logic             outValid;
  logic             outLast;
  logic             busy;
  logic             err;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: pending scan bits and expected outputs
  logic scanQ[$];
  logic mOut = 1'b0;
  logic mValid = 1'b0;
  logic mLast = 1'b0;
  logic mBusy = 1'b0;
  logic mErr = 1'b0;

  regread_scan #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctrl      (ctrlIn),
    .start     (startIn),
    .rin       (rinIn),
    .out       (out),
    .out_valid (outValid),
    .out_last  (outLast),
    .busy      (busy),
    .err       (err)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Reference model: a scan is a queue of the remaining snapshot bits; a
  // single read picks the selected bit; busy covers every cycle a scan bit
  // is on the line, and start is honoured only once busy has dropped.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        scanQ.delete();
        mOut   = 1'b0;
        mValid = 1'b0;
        mLast  = 1'b0;
        mBusy  = 1'b0;
        mErr   = 1'b0;
      end else begin
        mErr  = 1'b0;
        mLast = 1'b0;
        if (scanQ.size() > 0) begin
          mOut   = scanQ.pop_front();
          mValid = 1'b1;
          mBusy  = 1'b1;
          mLast  = (scanQ.size() == 0);
        end else if (startIn && !mBusy) begin
          mOut = rinIn[0];
          for (int i = 1; i < WIDTH; i++) scanQ.push_back(rinIn[i]);
          mValid = 1'b1;
          mBusy  = 1'b1;
        end else begin
          mBusy = 1'b0;
          if ($countones(ctrlIn) == 1) begin
            for (int i = 0; i < WIDTH; i++) if (ctrlIn[i]) mOut = rinIn[i];
            mValid = 1'b1;
          end else if ($countones(ctrlIn) > 1) begin
            mErr   = 1'b1;
            mValid = 1'b0;
          end else begin
            mValid = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of the DUT against the model, away from the edge
  initial begin
    forever begin
      @(negedge clk);
      checkCount++;
      if (out !== mOut || outValid !== mValid || outLast !== mLast ||
          busy !== mBusy || err !== mErr) begin
        errorCount++;
        $display("[TB] FAIL model t=%0t: got out=%b v=%b l=%b b=%b e=%b, want out=%b v=%b l=%b b=%b e=%b",
                 $time, out, outValid, outLast, busy, err,
                 mOut, mValid, mLast, mBusy, mErr);
      end
    end
  end

  // Drive one cycle of inputs and wait until the resulting outputs settle
  task automatic applyStimulus(input logic [WIDTH-1:0] c, input logic s,
                               input logic [WIDTH-1:0] r);
    ctrlIn  = c;
    startIn = s;
    rinIn   = r;
    @(negedge clk);
  endtask

  // Compare current DUT outputs against hand-computed literals
  task automatic checkOutput(input string name, input logic eOut,
                             input logic eValid, input logic eLast,
                             input logic eBusy, input logic eErr);
    checkCount++;
    if (out !== eOut || outValid !== eValid || outLast !== eLast ||
        busy !== eBusy || err !== eErr) begin
      errorCount++;
      $display("[TB] FAIL %s: got out=%b v=%b l=%b b=%b e=%b, want out=%b v=%b l=%b b=%b e=%b",
               name, out, outValid, outLast, busy, err,
               eOut, eValid, eLast, eBusy, eErr);
    end
  endtask

  // Directed test sequence
  initial begin
    logic [WIDTH-1:0] wr;
    int               posSeq[5];
    logic             dataSeq[5];

    repeat (3) @(negedge clk);
    checkOutput("resetHeld", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 1'b0, 4'b1101);
    checkOutput("resetIdle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] single-bit reads");
    applyStimulus(4'b0100, 1'b0, 4'b1101);
    checkOutput("read2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 4'b1101);
    checkOutput("read1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b1101);
    checkOutput("readIdle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] full scan");
    applyStimulus(4'b0000, 1'b1, 4'b1101);
    checkOutput("scan0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b1101);
    checkOutput("scan1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b1101);
    checkOutput("scan2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b1101);
    checkOutput("scan3", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b1101);
    checkOutput("scanDone", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] scan ignores inputs while shifting");
    applyStimulus(4'b0000, 1'b1, 4'b1101);
    checkOutput("ignore0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b1000, 1'b1, 4'b0000);
    checkOutput("ignore1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b1000, 1'b1, 4'b0000);
    checkOutput("ignore2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b1000, 1'b1, 4'b0000);
    checkOutput("ignore3", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 4'b0000);
    checkOutput("startOnLast", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] multi-bit ctrl");
    applyStimulus(4'b0011, 1'b0, 4'b1101);
    checkOutput("errPulse", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 4'b1101);
    checkOutput("errClear", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0011, 1'b1, 4'b1101);
    checkOutput("startBeatsErr", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(4'b0000, 1'b0, 4'b1101);
    checkOutput("errScanLast", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b1101);

    $display("[TB] reset mid-scan");
    applyStimulus(4'b0000, 1'b1, 4'b1101);
    applyStimulus(4'b0000, 1'b0, 4'b1101);
    checkOutput("abortBit1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("asyncReset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0000, 1'b0, 4'b1101);
      checkOutput("postReset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] writer replay");
    posSeq  = '{0, 0, 2, 1, 3};
    dataSeq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    wr = '0;
    for (int k = 0; k < 5; k++) begin
      wr[posSeq[k]] = dataSeq[k];
      applyStimulus(WIDTH'(1) << posSeq[k], 1'b0, wr);
      checkOutput("replay", dataSeq[k], 1'b1, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(4'b0000, 1'b0, wr);
    checkOutput("replayIdle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
